// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, program-memory reads and AVR two-word detection
// Latches one- or two-word instructions for decode; pc_load redirects and aborts fetches.
module fetch_unit #(
  parameter int                    PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_PM,
  input  logic                en_Fetch,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_target,
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic                pm_rd,
  input  logic [15:0]         pm_data,
  output logic [15:0]         ir,
  output logic [15:0]         ir2,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  output logic                long_instr,
  output logic                fetch_stall,
  output logic [PC_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WORD2 = 2'd2,
    S_WAIT2 = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [15:0]         ir2_q, ir2_d;
  logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                long_q, long_d;
  logic                word_is_long;

  // JMP/CALL and LDS/STS carry an address in the following program word.
  assign word_is_long = ((pm_data & 16'hFE0C) == 16'h940C) ||
                        ((pm_data & 16'hFC0F) == 16'h9000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      ir_q       <= 16'h0000;
      ir2_q      <= 16'h0000;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir2_q      <= ir2_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir2_d       = ir2_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    long_d      = long_q;
    pm_rd       = 1'b0;
    fetch_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        pm_rd = en_PM;
        if (en_PM) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (en_Fetch) begin
          ir_d       = pm_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_ONE;
          if (word_is_long) begin
            fetch_stall = 1'b1;
            state_d     = S_WORD2;
          end else begin
            valid_d = 1'b1;
            long_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_WORD2: begin
        pm_rd       = 1'b1;
        fetch_stall = 1'b1;
        state_d     = S_WAIT2;
      end
      S_WAIT2: begin
        ir2_d   = pm_data;
        pc_d    = pc_q + PC_ONE;
        long_d  = 1'b1;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect wins over everything and leaves the decode-facing registers untouched.
    if (pc_load) begin
      pc_d        = pc_target;
      state_d     = S_IDLE;
      valid_d     = 1'b0;
      fetch_stall = 1'b0;
      ir_d        = ir_q;
      ir2_d       = ir2_q;
      instr_pc_d  = instr_pc_q;
      long_d      = long_q;
    end
  end

  assign pm_addr     = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir2         = ir2_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign long_instr  = long_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a fetch-level reference model
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        en_PM;
  logic        en_Fetch;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] pm_addr;
  logic        pm_rd;
  logic [15:0] pm_data;
  logic [15:0] ir;
  logic [15:0] ir2;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        long_instr;
  logic        fetch_stall;
  logic [15:0] pc;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];

  logic [15:0] exp_pc, exp_ir, exp_ir2, exp_instr_pc;
  logic        exp_valid, exp_long;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .en_PM      (en_PM),
    .en_Fetch   (en_Fetch),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .pm_addr    (pm_addr),
    .pm_rd      (pm_rd),
    .pm_data    (pm_data),
    .ir         (ir),
    .ir2        (ir2),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .long_instr (long_instr),
    .fetch_stall(fetch_stall),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program memory: word appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (pm_rd) pm_data <= mem[pm_addr];
  end

  function automatic bit is_long(input logic [15:0] w);
    return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    exp_pc = 16'h0000; exp_ir = 16'h0000; exp_ir2 = 16'h0000;
    exp_instr_pc = 16'h0000; exp_valid = 1'b0; exp_long = 1'b0;
  endtask

  task automatic check_state(input string tag);
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL %s pc got=%h exp=%h", tag, pc, exp_pc); end
    checks++; if (ir !== exp_ir) begin errors++; $display("FAIL %s ir got=%h exp=%h", tag, ir, exp_ir); end
    checks++; if (instr_pc !== exp_instr_pc) begin errors++; $display("FAIL %s instr_pc got=%h exp=%h", tag, instr_pc, exp_instr_pc); end
    checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL %s instr_valid got=%b exp=%b", tag, instr_valid, exp_valid); end
    checks++; if (long_instr !== exp_long) begin errors++; $display("FAIL %s long_instr got=%b exp=%b", tag, long_instr, exp_long); end
    if (exp_long) begin
      checks++; if (ir2 !== exp_ir2) begin errors++; $display("FAIL %s ir2 got=%h exp=%h", tag, ir2, exp_ir2); end
    end
  endtask

  task automatic load_pc(input logic [15:0] t);
    pc_load = 1'b1; pc_target = t;
    tick;
    pc_load = 1'b0;
    exp_pc = t; exp_valid = 1'b0;
    checks++; if (pc !== t) begin errors++; $display("FAIL load_pc got=%h exp=%h", pc, t); end
  endtask

  task automatic do_fetch(input string tag);
    logic [15:0] w1;
    bit          lg;
    w1 = mem[exp_pc];
    lg = is_long(w1);
    en_PM = 1'b1;
    #1;
    checks++; if (pm_rd !== 1'b1) begin errors++; $display("FAIL %s pm_rd_req got=%b exp=1", tag, pm_rd); end
    checks++; if (pm_addr !== exp_pc) begin errors++; $display("FAIL %s pm_addr got=%h exp=%h", tag, pm_addr, exp_pc); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL %s stall_req got=%b exp=0", tag, fetch_stall); end
    tick;
    en_PM = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL %s valid_clr got=%b exp=0", tag, instr_valid); end
    en_Fetch = 1'b1;
    #1;
    checks++; if (fetch_stall !== lg) begin errors++; $display("FAIL %s stall_wait got=%b exp=%b", tag, fetch_stall, lg); end
    tick;
    en_Fetch = 1'b0;
    if (lg) begin
      #1;
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL %s stall_w2 got=%b exp=1", tag, fetch_stall); end
      checks++; if (pm_rd !== 1'b1) begin errors++; $display("FAIL %s pm_rd_w2 got=%b exp=1", tag, pm_rd); end
      checks++; if (pm_addr !== exp_pc + 16'd1) begin errors++; $display("FAIL %s pm_addr_w2 got=%h exp=%h", tag, pm_addr, exp_pc + 16'd1); end
      tick;
      #1;
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL %s stall_wait2 got=%b exp=0", tag, fetch_stall); end
      tick;
    end
    exp_ir = w1;
    exp_instr_pc = exp_pc;
    exp_pc = exp_pc + 16'd1;
    if (lg) begin
      exp_ir2 = mem[exp_pc];
      exp_pc = exp_pc + 16'd1;
    end
    exp_long = lg;
    exp_valid = 1'b1;
    check_state(tag);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", ir); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", fetch_stall); end
    #11;
    reset = 1'b1;
    tick;
    check_state("reset_release");
  endtask

  task automatic test_single;
    mem[0] = 16'h0C01;
    do_fetch("single_add");
  endtask

  task automatic test_jmp;
    mem[4] = 16'h940C; mem[5] = 16'h0123;
    load_pc(16'h0004);
    do_fetch("jmp");
    checks++; if (ir2 !== 16'h0123 || pc !== 16'h0006) begin errors++; $display("FAIL jmp_words ir2=%h pc=%h exp 0123/0006", ir2, pc); end
  endtask

  task automatic test_lds_sts;
    mem[16'h10] = 16'h9100; mem[16'h11] = 16'h1111;
    mem[16'h12] = 16'h9300; mem[16'h13] = 16'h2222;
    mem[16'h14] = 16'h9101;
    load_pc(16'h0010);
    do_fetch("lds");
    do_fetch("sts");
    do_fetch("not_long_9101");
  endtask

  task automatic test_wrap;
    mem[16'hFFFF] = 16'h2C01;
    load_pc(16'hFFFF);
    do_fetch("wrap");
  endtask

  task automatic test_random;
    logic [15:0] a, r;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      r = 16'($urandom);
      case ($urandom_range(0, 2))
        0: mem[a] = r;
        1: mem[a] = 16'h940C | (r & 16'h01F3);
        default: mem[a] = 16'h9000 | (r & 16'h03F0);
      endcase
      mem[a + 16'd1] = 16'($urandom);
      load_pc(a);
      do_fetch("random");
    end
  endtask

  task automatic test_pcload_word2;
    mem[16'h20] = 16'h940E; mem[16'h21] = 16'hABCD;
    mem[16'h40] = 16'h0F00;
    load_pc(16'h0020);
    en_PM = 1'b1; tick; en_PM = 1'b0;
    en_Fetch = 1'b1; tick; en_Fetch = 1'b0;
    pc_load = 1'b1; pc_target = 16'h0040;
    #1;
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL abort_w2_stall got=%b exp=0", fetch_stall); end
    tick;
    pc_load = 1'b0;
    exp_ir = 16'h940E; exp_instr_pc = 16'h0020; exp_pc = 16'h0040; exp_valid = 1'b0;
    check_state("abort_w2");
    checks++; if (ir2 !== exp_ir2) begin errors++; $display("FAIL abort_w2_ir2 got=%h exp=%h", ir2, exp_ir2); end
    do_fetch("after_abort");
  endtask

  task automatic test_load_vs_fetch;
    mem[16'h30] = 16'h940C;
    load_pc(16'h0030);
    en_PM = 1'b1; tick; en_PM = 1'b0;
    en_Fetch = 1'b1; pc_load = 1'b1; pc_target = 16'h0050;
    #1;
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL load_vs_fetch_stall got=%b exp=0", fetch_stall); end
    tick;
    en_Fetch = 1'b0; pc_load = 1'b0;
    exp_pc = 16'h0050; exp_valid = 1'b0;
    check_state("load_vs_fetch");
  endtask

  task automatic test_reset_mid_wait;
    mem[8] = 16'h1234;
    load_pc(16'h0008);
    en_PM = 1'b1; tick; en_PM = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_state("reset_mid_wait");
    checks++; if (ir2 !== 16'h0000) begin errors++; $display("FAIL reset_mid_wait_ir2 got=%h exp=0000", ir2); end
    #2;
    reset = 1'b1;
    tick;
    mem[0] = 16'h0C01;
    do_fetch("after_reset");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    reset = 1'b0; en_PM = 1'b0; en_Fetch = 1'b0; pc_load = 1'b0;
    pc_target = 16'h0000; pm_data = 16'h0000;
    model_reset();
    test_reset();
    test_single();
    test_jmp();
    test_lds_sts();
    test_wrap();
    test_random();
    test_pcload_word2();
    test_load_vs_fetch();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage driven by the Control_Unit enables en_PM and en_Fetch. It owns the program counter, issues reads to the synchronous program memory, and latches the instruction register for the decode stage. It detects AVR two-word instructions (JMP, CALL, LDS, STS), fetches the second word itself, and raises fetch_stall so the control unit holds in fetch while it does. It accepts PC redirects from the execute/writeback stage.

Parameters:
PC_WIDTH, 16, program-counter and program-memory word-address width.
RESET_VECTOR, 0, PC value loaded at reset.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
en_PM  in  1  control-unit request to start an instruction fetch.
en_Fetch  in  1  control-unit strobe to capture the program-memory word.
pc_load  in  1  redirect PC (branch, jump, call, return); sampled every cycle.
pc_target  in  PC_WIDTH  new PC when pc_load=1.
pm_addr  out  PC_WIDTH  program-memory word address; combinational from the PC register.
pm_rd  out  1  program-memory read strobe; combinational.
pm_data  in  16  program-memory read data; valid in the cycle after pm_rd.
ir  out  16  instruction word 1.
ir2  out  16  instruction word 2; valid only when long_instr=1.
instr_pc  out  PC_WIDTH  address of word 1 of the current instruction.
instr_valid  out  1  ir, ir2, instr_pc and long_instr are valid for decode.
long_instr  out  1  current instruction is two words.
fetch_stall  out  1  control unit must stay in the fetch state.
pc  out  PC_WIDTH  current PC register.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VECTOR, ir=0x0000 (NOP), ir2=0, instr_pc=0, instr_valid=0, long_instr=0, state=S_IDLE. Mid-operation reset aborts immediately. No partial capture survives.
- FSM states: S_IDLE, S_WAIT, S_WORD2, S_WAIT2.
- S_IDLE:
  - pm_rd=en_PM and pm_addr=pc.
  - If en_PM=1, instr_valid<=0 and go to S_WAIT.
  - en_Fetch in S_IDLE is ignored.
- S_WAIT:
  - pm_rd=0.
  - If en_Fetch=1: ir<=pm_data, instr_pc<=pc, pc<=pc+1.
  - If long(pm_data): fetch_stall=1 (combinational, same cycle) and go to S_WORD2.
  - Otherwise: instr_valid<=1, long_instr<=0, go to S_IDLE.
  - If en_Fetch=0: hold in S_WAIT.
- long(w) is true when (w & 0xFE0C)==0x940C (JMP/CALL) or (w & 0xFC0F)==0x9000 (LDS/STS).
- S_WORD2: pm_rd=1, pm_addr=pc (already incremented), fetch_stall=1; go to S_WAIT2 unconditionally.
- S_WAIT2:
  - fetch_stall=0.
  - ir2<=pm_data, pc<=pc+1, long_instr<=1, instr_valid<=1; go to S_IDLE.
  - The control unit advances to decode on this edge.
- Latency:
  - Single-word instruction: en_PM cycle plus en_Fetch cycle; instr_valid high from the edge ending the en_Fetch cycle.
  - Two-word instruction: two further cycles.
- PC arithmetic is modulo 2^PC_WIDTH; all-ones+1 wraps to 0 without error.
- pc_load=1:
  - pc<=pc_target, with priority over any increment in the same cycle.
  - State forced to S_IDLE; instr_valid<=0; fetch_stall=0 that cycle; ir/ir2 are not updated.
  - A pc_load in S_WORD2 or S_WAIT2 aborts the second-word fetch.
- en_PM outside S_IDLE is ignored.
- instr_valid stays high until the next accepted en_PM or pc_load.
- ir, ir2, instr_pc and long_instr hold their values between captures.

Test Plan:
- Reset, then release with RESET_VECTOR=0: pc=0, ir=0x0000, instr_valid=0. Assert reset mid-S_WAIT -> outputs return to reset values immediately, without waiting for a clock edge.
- Memory[0]=0x0C01 (ADD); en_PM then en_Fetch -> pm_rd=1 with pm_addr=0 in the en_PM cycle; ir=0x0C01, instr_pc=0, pc=1, instr_valid=1, long_instr=0, fetch_stall never high.
- Memory[4]=0x940C, memory[5]=0x0123 (JMP), pc=4 -> fetch_stall high for 2 cycles; second read at pm_addr=5; ir=0x940C, ir2=0x0123, long_instr=1, pc=6.
- LDS 0x9100 followed by STS 0x9300 -> each detected as long. Word 0x9101 -> not long.
- pc=0xFFFF, single-word fetch -> pc wraps to 0x0000.
- pc_load=1 with pc_target=0x0040 during S_WORD2 -> pc=0x0040, state S_IDLE, instr_valid=0, ir2 unchanged. pc_load coincident with en_Fetch in S_WAIT -> pc=target, ir unchanged.
